umi_host_initiator: RTL and testbench
=====================================

Name: umi_host_initiator

Overview:
- Host-side UMI request initiator. It is the requester end of the host request/response path.
- Accepts one simple transaction command at a time, builds and drives a UMI request, then waits for and checks the matching UMI response.
- Returns read data plus a status code to the local controller.
- Connects directly, or through umi_fifo, to a UMI device such as umi_mem_agent; replaces the switchboard host agents in synthesizable benches.

Parameters:
- DW, 128, UMI data width
- AW, 64, UMI address width
- CW, 32, UMI command width
- HOSTADDR, 64'h0, value driven on request srcaddr and required on response dstaddr
- TOW, 16, timeout counter width
- TIMEOUT, 1000, cycles allowed in WAIT_RESP before a timeout error; range 1..2^TOW-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- go_valid  in  1  command valid
- go_ready  out  1  command accepted (high only in IDLE)
- go_write  in  1  1=write, 0=read
- go_posted  in  1  write without response (ignored for reads)
- go_addr  in  AW  target address
- go_size  in  3  log2 bytes per word
- go_len  in  8  words minus 1
- go_data  in  DW  write data
- done_valid  out  1  transaction complete
- done_ready  in  1  completion accepted
- done_err  out  2  0=ok, 1=bad opcode, 2=dstaddr mismatch, 3=timeout
- done_data  out  DW  read response data (0 for writes)
- stray_count  out  8  saturating count of unsolicited responses
- uhost_req_valid  out  1
- uhost_req_ready  in  1
- uhost_req_cmd  out  CW
- uhost_req_dstaddr  out  AW
- uhost_req_srcaddr  out  AW
- uhost_req_data  out  DW
- uhost_resp_valid  in  1
- uhost_resp_ready  out  1
- uhost_resp_cmd  in  CW
- uhost_resp_dstaddr  in  AW
- uhost_resp_srcaddr  in  AW
- uhost_resp_data  in  DW

Behaviour:
- Clocking and reset:
  - Single clock clk; reset is synchronous, active-high.
  - While reset is high, all outputs are 0 and the state is IDLE.
- cmd encoding:
  - cmd[4:0] opcode; cmd[7:5] size; cmd[15:8] len; upper bits 0.
  - Opcodes: REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05, RESP_READ=0x02, RESP_WRITE=0x04.
- States: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - go_ready=1 and uhost_resp_ready=1.
  - go handshake in cycle N: register cmd/addr/data; state becomes REQ; uhost_req_valid=1 from cycle N+1.
  - A response accepted in IDLE is dropped and stray_count increments, saturating at 255.
- REQ:
  - All uhost_req_* outputs held stable while valid && !ready.
  - On the uhost_req handshake: posted write goes to DONE (err=0); read or write goes to WAIT_RESP with timer cleared to 0.
  - uhost_resp_ready=0 in REQ.
- WAIT_RESP:
  - uhost_resp_ready=1; timer increments every cycle.
  - Response handshake at cycle M: done_valid=1 at M+1.
  - Error priority: opcode mismatch (expected RESP_READ for a read, RESP_WRITE for a write) -> err=1; else dstaddr!=HOSTADDR -> err=2; else err=0.
  - done_data = resp data for an error-free read, else 0.
  - Timer reaching TIMEOUT-1 with no response -> DONE, err=3.
  - A response in the same cycle as timer expiry wins: it is checked normally, no timeout.
- DONE:
  - done_valid held with stable data and err until done_ready, then return to IDLE.
  - go_ready=0. uhost_resp_ready=1; responses are dropped and counted as stray (covers late responses after a timeout).
- Throughput: at most one outstanding transaction. A done handshake and a new go cannot occur in the same cycle; go is accepted from the next cycle.
- Reset asserted mid-transaction: abandon immediately. Any in-flight response later arriving in IDLE is counted as stray.

Decomposition:
- Package umi_pkg holds:
  - opcode localparams;
  - the cmd field offsets;
  - the status code enum (OK, BAD_OPC, BAD_ADDR, TIMEOUT);
  - the state enum.
- Sub-module umi_cmd_pack (combinational opcode/size/len -> cmd) is shared with future initiators. Everything else lives in a flat FSM.

Test Plan:
- Read, device ready: go addr=0x100, size=3, len=0 to umi_mem_agent preloaded with 0xDEADBEEF -> req cmd=0x00000061, srcaddr=HOSTADDR; done_err=0, done_data=0xDEADBEEF.
- Write then read-back: write 0xA5A5 to 0x200, then read 0x200 -> write done_err=0, read done_data=0xA5A5. Repeat with random uhost_req_ready and done_ready stalls; outputs stay stable under backpressure.
- Posted write: go_posted=1 -> done_valid exactly 1 cycle after the req handshake, err=0. Responder sends no response, and stray_count stays 0.
- Timeout: TIMEOUT=8 with a silent responder -> done_err=3 exactly 8 cycles after the req handshake. A response injected afterwards -> stray_count=1.
- Bad response: reply to a read with opcode 0x04 -> err=1. Reply with dstaddr=HOSTADDR+1 -> err=2. Response on the expiry cycle -> err=0 with no timeout.
- Reset mid-WAIT_RESP: assert reset 1 cycle -> all outputs 0, go_ready=1 next cycle. The late response is counted as stray; 300 stray responses leave stray_count saturated at 255.

Source files
------------

// File: rtl/umi_pkg.sv
// Shared UMI definitions: opcodes, cmd field layout, initiator status codes and FSM states.
package umi_pkg;

    localparam logic [4:0] OpReqRead   = 5'h01;
    localparam logic [4:0] OpRespRead  = 5'h02;
    localparam logic [4:0] OpReqWrite  = 5'h03;
    localparam logic [4:0] OpRespWrite = 5'h04;
    localparam logic [4:0] OpReqPosted = 5'h05;

    localparam int unsigned CmdOpcLsb  = 0;
    localparam int unsigned CmdSizeLsb = 5;
    localparam int unsigned CmdLenLsb  = 8;

    typedef enum logic [1:0] {
        StatOk      = 2'd0,
        StatBadOpc  = 2'd1,
        StatBadAddr = 2'd2,
        StatTimeout = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StReq      = 2'd1,
        StWaitResp = 2'd2,
        StDone     = 2'd3
    } state_e;

endpackage

// File: rtl/umi_cmd_pack.sv
// Packs opcode/size/len into a UMI command word; all bits above len are zero.
module umi_cmd_pack
    import umi_pkg::*;
#(
    parameter int unsigned CW = 32
) (
    input  logic [4:0]    opcode_i,
    input  logic [2:0]    size_i,
    input  logic [7:0]    len_i,
    output logic [CW-1:0] cmd_o
);

    always_comb begin
        cmd_o = '0;
        cmd_o[CmdOpcLsb  +: 5] = opcode_i;
        cmd_o[CmdSizeLsb +: 3] = size_i;
        cmd_o[CmdLenLsb  +: 8] = len_i;
    end

endmodule

// File: rtl/umi_host_initiator.sv
// Host-side UMI requester: one command in flight, issues the request, checks the response
// and reports read data plus status to the local controller.
module umi_host_initiator
    import umi_pkg::*;
#(
    parameter int unsigned   DW       = 128,
    parameter int unsigned   AW       = 64,
    parameter int unsigned   CW       = 32,
    parameter logic [AW-1:0] HOSTADDR = '0,
    parameter int unsigned   TOW      = 16,
    parameter int unsigned   TIMEOUT  = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go_valid,
    output logic          go_ready,
    input  logic          go_write,
    input  logic          go_posted,
    input  logic [AW-1:0] go_addr,
    input  logic [2:0]    go_size,
    input  logic [7:0]    go_len,
    input  logic [DW-1:0] go_data,
    output logic          done_valid,
    input  logic          done_ready,
    output logic [1:0]    done_err,
    output logic [DW-1:0] done_data,
    output logic [7:0]    stray_count,
    output logic          uhost_req_valid,
    input  logic          uhost_req_ready,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_resp_valid,
    output logic          uhost_resp_ready,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data
);

    // Expiry is checked one cycle early so done_valid lands TIMEOUT cycles after the request
    // handshake; a response arriving on the expiry cycle still takes priority.
    localparam logic [TOW-1:0] ExpireAt = TOW'((TIMEOUT > 1) ? (TIMEOUT - 2) : 0);

    state_e         state_q, state_d;
    logic           write_q, write_d;
    logic           posted_q, posted_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [2:0]     size_q, size_d;
    logic [7:0]     len_q, len_d;
    logic [DW-1:0]  data_q, data_d;
    logic [TOW-1:0] timer_q, timer_d;
    status_e        err_q, err_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [7:0]     stray_q, stray_d;

    logic           resp_hs;
    logic [4:0]     req_opc;
    logic [4:0]     exp_opc;
    logic [CW-1:0]  req_cmd;

    logic unused_resp;
    assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_cmd};

    assign req_opc = !write_q ? OpReqRead : (posted_q ? OpReqPosted : OpReqWrite);
    assign exp_opc = write_q ? OpRespWrite : OpRespRead;
    assign resp_hs = uhost_resp_valid && (state_q != StReq);

    umi_cmd_pack #(
        .CW (CW)
    ) u_cmd_pack (
        .opcode_i (req_opc),
        .size_i   (size_q),
        .len_i    (len_q),
        .cmd_o    (req_cmd)
    );

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        posted_d = posted_q;
        addr_d   = addr_q;
        size_d   = size_q;
        len_d    = len_q;
        data_d   = data_q;
        timer_d  = timer_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        stray_d  = stray_q;

        if (resp_hs && (state_q != StWaitResp) && (stray_q != 8'hff)) begin
            stray_d = stray_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (go_valid) begin
                    write_d  = go_write;
                    posted_d = go_write & go_posted;
                    addr_d   = go_addr;
                    size_d   = go_size;
                    len_d    = go_len;
                    data_d   = go_data;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (uhost_req_ready) begin
                    if (posted_q) begin
                        err_d   = StatOk;
                        rdata_d = '0;
                        state_d = StDone;
                    end else begin
                        timer_d = '0;
                        state_d = StWaitResp;
                    end
                end
            end
            StWaitResp: begin
                if (uhost_resp_valid) begin
                    state_d = StDone;
                    rdata_d = '0;
                    if (uhost_resp_cmd[CmdOpcLsb +: 5] != exp_opc) begin
                        err_d = StatBadOpc;
                    end else if (uhost_resp_dstaddr != HOSTADDR) begin
                        err_d = StatBadAddr;
                    end else begin
                        err_d = StatOk;
                        if (!write_q) rdata_d = uhost_resp_data;
                    end
                end else if (timer_q == ExpireAt) begin
                    state_d = StDone;
                    err_d   = StatTimeout;
                    rdata_d = '0;
                end else begin
                    timer_d = timer_q + TOW'(1);
                end
            end
            StDone: begin
                if (done_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            posted_q <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            timer_q  <= '0;
            err_q    <= StatOk;
            rdata_q  <= '0;
            stray_q  <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            posted_q <= posted_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            len_q    <= len_d;
            data_q   <= data_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            stray_q  <= stray_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, not just after the first edge.
    assign go_ready          = !reset && (state_q == StIdle);
    assign uhost_resp_ready  = !reset && (state_q != StReq);
    assign uhost_req_valid   = !reset && (state_q == StReq);
    assign done_valid        = !reset && (state_q == StDone);
    assign done_err          = reset ? 2'd0 : err_q;
    assign done_data         = reset ? '0 : rdata_q;
    assign stray_count       = reset ? 8'd0 : stray_q;
    assign uhost_req_cmd     = reset ? '0 : req_cmd;
    assign uhost_req_dstaddr = reset ? '0 : addr_q;
    assign uhost_req_srcaddr = reset ? '0 : HOSTADDR;
    assign uhost_req_data    = reset ? '0 : data_q;

endmodule

// File: tb/tb_umi_host_initiator.sv
// Directed self-checking bench for umi_host_initiator; the bench itself plays the UMI device.
module tb_umi_host_initiator;

    localparam logic [63:0] Host = 64'h1000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         go_valid = 1'b0;
    logic         go_ready;
    logic         go_write = 1'b0;
    logic         go_posted = 1'b0;
    logic [63:0]  go_addr = '0;
    logic [2:0]   go_size = '0;
    logic [7:0]   go_len = '0;
    logic [127:0] go_data = '0;
    logic         done_valid;
    logic         done_ready = 1'b0;
    logic [1:0]   done_err;
    logic [127:0] done_data;
    logic [7:0]   stray_count;
    logic         uhost_req_valid;
    logic         uhost_req_ready = 1'b1;
    logic [31:0]  uhost_req_cmd;
    logic [63:0]  uhost_req_dstaddr;
    logic [63:0]  uhost_req_srcaddr;
    logic [127:0] uhost_req_data;
    logic         uhost_resp_valid = 1'b0;
    logic         uhost_resp_ready;
    logic [31:0]  uhost_resp_cmd = '0;
    logic [63:0]  uhost_resp_dstaddr = '0;
    logic [63:0]  uhost_resp_srcaddr = '0;
    logic [127:0] uhost_resp_data = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    umi_host_initiator #(
        .DW       (128),
        .AW       (64),
        .CW       (32),
        .HOSTADDR (Host),
        .TOW      (16),
        .TIMEOUT  (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .go_valid           (go_valid),
        .go_ready           (go_ready),
        .go_write           (go_write),
        .go_posted          (go_posted),
        .go_addr            (go_addr),
        .go_size            (go_size),
        .go_len             (go_len),
        .go_data            (go_data),
        .done_valid         (done_valid),
        .done_ready         (done_ready),
        .done_err           (done_err),
        .done_data          (done_data),
        .stray_count        (stray_count),
        .uhost_req_valid    (uhost_req_valid),
        .uhost_req_ready    (uhost_req_ready),
        .uhost_req_cmd      (uhost_req_cmd),
        .uhost_req_dstaddr  (uhost_req_dstaddr),
        .uhost_req_srcaddr  (uhost_req_srcaddr),
        .uhost_req_data     (uhost_req_data),
        .uhost_resp_valid   (uhost_resp_valid),
        .uhost_resp_ready   (uhost_resp_ready),
        .uhost_resp_cmd     (uhost_resp_cmd),
        .uhost_resp_dstaddr (uhost_resp_dstaddr),
        .uhost_resp_srcaddr (uhost_resp_srcaddr),
        .uhost_resp_data    (uhost_resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_go(input logic w, input logic p, input logic [63:0] a,
                           input logic [2:0] s, input logic [7:0] l, input logic [127:0] d,
                           output bit ok);
        ok = 1'b0;
        go_valid = 1'b1; go_write = w; go_posted = p;
        go_addr = a; go_size = s; go_len = l; go_data = d;
        for (int i = 0; i < 20; i++) begin
            if (go_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        go_valid = 1'b0;
    endtask

    task automatic take_req(output logic [31:0] cmd, output logic [63:0] dst,
                            output logic [63:0] src, output logic [127:0] data,
                            output int hs, output bit ok);
        ok = 1'b0; hs = 0; cmd = '0; dst = '0; src = '0; data = '0;
        uhost_req_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (uhost_req_valid) begin
                cmd = uhost_req_cmd; dst = uhost_req_dstaddr;
                src = uhost_req_srcaddr; data = uhost_req_data;
                hs = cyc;
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic send_resp(input logic [31:0] cmd, input logic [63:0] dst,
                             input logic [127:0] data, output bit ok);
        ok = 1'b0;
        uhost_resp_valid = 1'b1; uhost_resp_cmd = cmd;
        uhost_resp_dstaddr = dst; uhost_resp_data = data; uhost_resp_srcaddr = 64'h40;
        for (int i = 0; i < 20; i++) begin
            if (uhost_resp_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        uhost_resp_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [1:0] err, output logic [127:0] data,
                             output int seen, output bit ok);
        ok = 1'b0; seen = 0; err = '0; data = '0;
        for (int i = 0; i < 40; i++) begin
            if (done_valid) begin
                err = done_err; data = done_data; seen = cyc;
                done_ready = 1'b1;
                tick();
                done_ready = 1'b0;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (go_ready !== 1'b0) begin bad++; $display("FAIL rst_go_ready got=%b exp=0", go_ready); end
        total++; if (uhost_resp_ready !== 1'b0) begin bad++; $display("FAIL rst_resp_ready got=%b exp=0", uhost_resp_ready); end
        total++; if ({uhost_req_valid, done_valid, stray_count} !== 10'd0) begin bad++; $display("FAIL rst_outs got=%b/%b/%0d exp=0/0/0", uhost_req_valid, done_valid, stray_count); end
        reset = 1'b0;
        tick();
        total++; if (go_ready !== 1'b1) begin bad++; $display("FAIL idle_go_ready got=%b exp=1", go_ready); end
        total++; if (uhost_resp_ready !== 1'b1) begin bad++; $display("FAIL idle_resp_ready got=%b exp=1", uhost_resp_ready); end
    endtask

    task automatic test_read();
        logic [31:0] c; logic [63:0] d, s; logic [127:0] x, rd; logic [1:0] e;
        int hs, seen; bit ok1, ok2, ok3, ok4;
        uhost_req_ready = 1'b0;
        send_go(1'b0, 1'b0, 64'h100, 3'd3, 8'd0, 128'h0, ok1);
        total++; if ({uhost_req_valid, go_ready, uhost_resp_ready} !== 3'b100) begin bad++; $display("FAIL rd_req_state got=%b exp=100", {uhost_req_valid, go_ready, uhost_resp_ready}); end
        take_req(c, d, s, x, hs, ok2);
        total++; if (c !== 32'h61) begin bad++; $display("FAIL rd_cmd got=%h exp=00000061", c); end
        total++; if (d !== 64'h100 || s !== Host) begin bad++; $display("FAIL rd_addr got=%h/%h exp=100/%h", d, s, Host); end
        send_resp(32'h62, Host, 128'hDEADBEEF, ok3);
        wait_done(e, rd, seen, ok4);
        total++; if ({ok1, ok2, ok3, ok4} !== 4'hf) begin bad++; $display("FAIL rd_handshakes got=%b exp=1111", {ok1, ok2, ok3, ok4}); end
        total++; if (e !== 2'd0) begin bad++; $display("FAIL rd_err got=%0d exp=0", e); end
        total++; if (rd !== 128'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_write_read();
        logic [31:0] c; logic [63:0] d, s; logic [127:0] wdata, x, rd; logic [1:0] e;
        int hs, seen; bit ok1, ok2, ok3, ok4;
        send_go(1'b1, 1'b0, 64'h200, 3'd3, 8'd0, 128'hA5A5, ok1);
        take_req(c, d, s, wdata, hs, ok2);
        total++; if (c !== 32'h63 || d !== 64'h200) begin bad++; $display("FAIL wr_cmd got=%h/%h exp=00000063/200", c, d); end
        total++; if (wdata !== 128'hA5A5) begin bad++; $display("FAIL wr_data got=%h exp=a5a5", wdata); end
        send_resp(32'h64, Host, 128'h0, ok3);
        wait_done(e, rd, seen, ok4);
        total++; if ({ok1, ok2, ok3, ok4} !== 4'hf || e !== 2'd0 || rd !== 128'h0) begin bad++; $display("FAIL wr_done got=%b err=%0d data=%h exp=1111 0 0", {ok1, ok2, ok3, ok4}, e, rd); end
        send_go(1'b0, 1'b0, 64'h200, 3'd3, 8'd0, 128'h0, ok1);
        take_req(c, d, s, x, hs, ok2);
        send_resp(32'h62, Host, wdata, ok3);
        wait_done(e, rd, seen, ok4);
        total++; if ({ok1, ok2, ok3, ok4} !== 4'hf || e !== 2'd0) begin bad++; $display("FAIL rb_done got=%b err=%0d exp=1111 0", {ok1, ok2, ok3, ok4}, e); end
        total++; if (rd !== 128'hA5A5) begin bad++; $display("FAIL rb_data got=%h exp=a5a5", rd); end
    endtask

    task automatic test_backpressure();
        bit ok, acc, hs_seen;
        for (int pass = 0; pass < 2; pass++) begin
            send_go(pass == 0, 1'b0, 64'h300, 3'd3, 8'd0, 128'h5A5A, ok);
            hs_seen = 1'b0;
            for (int i = 0; i < 60 && !hs_seen; i++) begin
                uhost_req_ready = ($urandom_range(0, 3) == 0);
                if (uhost_req_valid) begin
                    total++;
                    if (uhost_req_cmd !== ((pass == 0) ? 32'h63 : 32'h61) || uhost_req_dstaddr !== 64'h300
                        || ((pass == 0) && uhost_req_data !== 128'h5A5A)) begin
                        bad++; $display("FAIL bp_req_stable got=%h/%h/%h pass=%0d", uhost_req_cmd, uhost_req_dstaddr, uhost_req_data, pass);
                    end
                    if (uhost_req_ready) hs_seen = 1'b1;
                end
                tick();
            end
            uhost_req_ready = 1'b1;
            send_resp((pass == 0) ? 32'h64 : 32'h62, Host, 128'h5A5A, ok);
            acc = 1'b0;
            for (int i = 0; i < 60 && !acc; i++) begin
                done_ready = ($urandom_range(0, 2) == 0);
                if (done_valid) begin
                    total++;
                    if (done_err !== 2'd0 || done_data !== ((pass == 0) ? 128'h0 : 128'h5A5A) || go_ready !== 1'b0) begin
                        bad++; $display("FAIL bp_done_stable got=err %0d data %h go_ready %b pass=%0d", done_err, done_data, go_ready, pass);
                    end
                    if (done_ready) acc = 1'b1;
                end
                tick();
            end
            done_ready = 1'b0;
            total++; if (!(hs_seen && acc && ok)) begin bad++; $display("FAIL bp_progress got=%b%b%b exp=111", hs_seen, acc, ok); end
        end
    endtask

    task automatic test_posted();
        logic [31:0] c; logic [63:0] d, s; logic [127:0] x, rd; logic [1:0] e;
        int hs, seen; bit ok1, ok2, ok4;
        send_go(1'b1, 1'b1, 64'h400, 3'd3, 8'd0, 128'h77, ok1);
        take_req(c, d, s, x, hs, ok2);
        total++; if (c !== 32'h65) begin bad++; $display("FAIL posted_cmd got=%h exp=00000065", c); end
        wait_done(e, rd, seen, ok4);
        total++; if (!ok4 || seen !== hs + 1) begin bad++; $display("FAIL posted_latency got=%0d exp=%0d", seen - hs, 1); end
        total++; if (e !== 2'd0) begin bad++; $display("FAIL posted_err got=%0d exp=0", e); end
        tick(); tick();
        total++; if (stray_count !== 8'd0) begin bad++; $display("FAIL posted_stray got=%0d exp=0", stray_count); end
    endtask

    task automatic test_timeout();
        logic [31:0] c; logic [63:0] d, s; logic [127:0] x;
        int hs, seen; bit ok1, ok2, ok3, found;
        send_go(1'b0, 1'b0, 64'h500, 3'd2, 8'd3, 128'h0, ok1);
        take_req(c, d, s, x, hs, ok2);
        total++; if (c !== 32'h341) begin bad++; $display("FAIL to_cmd got=%h exp=00000341", c); end
        found = 1'b0; seen = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done_valid) begin found = 1'b1; seen = cyc; end
            else tick();
        end
        total++; if (!found || seen !== hs + 8) begin bad++; $display("FAIL to_latency got=%0d exp=8", seen - hs); end
        total++; if (done_err !== 2'd3 || done_data !== 128'h0) begin bad++; $display("FAIL to_err got=%0d/%h exp=3/0", done_err, done_data); end
        send_resp(32'h62, Host, 128'hBAD, ok3);
        total++; if (!ok3 || stray_count !== 8'd1) begin bad++; $display("FAIL to_stray got=%0d ok=%b exp=1", stray_count, ok3); end
        total++; if (done_valid !== 1'b1 || done_err !== 2'd3) begin bad++; $display("FAIL to_hold got=%b/%0d exp=1/3", done_valid, done_err); end
        done_ready = 1'b1; tick(); done_ready = 1'b0;
    endtask

    task automatic test_bad_resp();
        logic [31:0] c; logic [63:0] d, s; logic [127:0] x, rd; logic [1:0] e;
        int hs, seen; bit ok1, ok2, ok3, ok4;
        send_go(1'b0, 1'b0, 64'h600, 3'd3, 8'd0, 128'h0, ok1);
        take_req(c, d, s, x, hs, ok2);
        send_resp(32'h64, Host, 128'h1234, ok3);
        wait_done(e, rd, seen, ok4);
        total++; if (e !== 2'd1 || rd !== 128'h0) begin bad++; $display("FAIL badopc got=%0d/%h exp=1/0", e, rd); end
        send_go(1'b0, 1'b0, 64'h600, 3'd3, 8'd0, 128'h0, ok1);
        take_req(c, d, s, x, hs, ok2);
        send_resp(32'h62, Host + 64'h1, 128'h1234, ok3);
        wait_done(e, rd, seen, ok4);
        total++; if (e !== 2'd2 || rd !== 128'h0) begin bad++; $display("FAIL badaddr got=%0d/%h exp=2/0", e, rd); end
        send_go(1'b0, 1'b0, 64'h600, 3'd3, 8'd0, 128'h0, ok1);
        take_req(c, d, s, x, hs, ok2);
        // Now one cycle into WAIT_RESP; land the response on the expiry cycle hs+7.
        for (int i = 0; i < 6; i++) tick();
        send_resp(32'h62, Host, 128'hCAFE, ok3);
        wait_done(e, rd, seen, ok4);
        total++; if (seen !== hs + 8 || e !== 2'd0) begin bad++; $display("FAIL expiry_race got=lat %0d err %0d exp=lat 8 err 0", seen - hs, e); end
        total++; if (rd !== 128'hCAFE) begin bad++; $display("FAIL expiry_data got=%h exp=cafe", rd); end
        total++; if (stray_count !== 8'd1) begin bad++; $display("FAIL bad_resp_stray got=%0d exp=1", stray_count); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c; logic [63:0] d, s; logic [127:0] x;
        int hs; bit ok1, ok2, ok3;
        send_go(1'b0, 1'b0, 64'h700, 3'd3, 8'd0, 128'h0, ok1);
        take_req(c, d, s, x, hs, ok2);
        tick(); tick();
        reset = 1'b1;
        #1;
        total++; if ({go_ready, uhost_resp_ready, uhost_req_valid, done_valid, stray_count} !== 12'd0) begin bad++; $display("FAIL midrst_outs got=%b%b%b%b/%0d exp=0000/0", go_ready, uhost_resp_ready, uhost_req_valid, done_valid, stray_count); end
        total++; if (uhost_req_cmd !== 32'h0 || uhost_req_srcaddr !== 64'h0) begin bad++; $display("FAIL midrst_req got=%h/%h exp=0/0", uhost_req_cmd, uhost_req_srcaddr); end
        tick();
        reset = 1'b0;
        #1;
        total++; if (go_ready !== 1'b1 || done_valid !== 1'b0) begin bad++; $display("FAIL postrst got=%b/%b exp=1/0", go_ready, done_valid); end
        send_resp(32'h62, Host, 128'h99, ok3);
        total++; if (!ok3 || stray_count !== 8'd1) begin bad++; $display("FAIL late_stray got=%0d exp=1", stray_count); end
        for (int i = 0; i < 300; i++) send_resp(32'h62, Host, 128'h99, ok3);
        total++; if (stray_count !== 8'd255) begin bad++; $display("FAIL stray_sat got=%0d exp=255", stray_count); end
        total++; if (go_ready !== 1'b1 || done_valid !== 1'b0) begin bad++; $display("FAIL stray_idle got=%b/%b exp=1/0", go_ready, done_valid); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_backpressure();
        test_posted();
        test_timeout();
        test_bad_resp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
